// File: rtl/combat_pkg.sv
// Shared types and constants for the turn-based combat resolver.
// Holds the move encoding, the sequencer states, the damage table and the winner codes.
package combat_pkg;

    typedef enum logic [1:0] {
        MV_LIGHT   = 2'd0,
        MV_HEAVY   = 2'd1,
        MV_SPECIAL = 2'd2,
        MV_GUARD   = 2'd3
    } move_t;

    typedef enum logic [3:0] {
        S_IDLE, S_LATCH, S_ATK1, S_STB1, S_WAIT1,
        S_ATK2, S_STB2, S_WAIT2, S_CHECK, S_OVER
    } state_t;

    localparam logic [5:0] DMG_LIGHT         = 6'd8;
    localparam logic [5:0] DMG_HEAVY         = 6'd16;
    localparam logic [5:0] DMG_SPECIAL       = 6'd30;
    localparam logic [4:0] HEAVY_DODGE_BONUS = 5'd2;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;
    localparam logic [1:0] WIN_DRAW = 2'd3;

    typedef struct packed {
        logic [5:0] dmg;
        logic [2:0] cost;
    } attack_t;

    // Raw attack before the defender's guard halving; an unaffordable special falls back to light.
    function automatic attack_t attack_of(input move_t mv, input logic [4:0] meter,
                                          input logic [4:0] need, input logic [2:0] cost);
        attack_t a;
        a.dmg  = 6'd0;
        a.cost = 3'd0;
        case (mv)
            MV_LIGHT:   a.dmg = DMG_LIGHT;
            MV_HEAVY:   a.dmg = DMG_HEAVY;
            MV_SPECIAL: begin
                if (meter >= need) begin
                    a.dmg  = DMG_SPECIAL;
                    a.cost = cost;
                end else begin
                    a.dmg = DMG_LIGHT;
                end
            end
            default:    a.dmg = 6'd0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/lfsr8_roller.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used as a dice source.
// A zero seed would lock the register, so it is replaced with 8'h01.
module lfsr8_roller (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seed,
    output logic [7:0] lfsr
);

    logic [7:0] r_lfsr;
    logic [7:0] w_seed;
    logic       w_fb;

    assign w_seed = (seed == 8'h00) ? 8'h01 : seed;
    assign w_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_lfsr <= w_seed;
        else     r_lfsr <= {r_lfsr[6:0], w_fb};
    end

    assign lfsr = r_lfsr;

endmodule

// File: rtl/combat_resolver.sv
// Turn sequencer: orders the two attacks by speed, rolls dodge, drives each stat block's
// damage/cost/enable bus plus an update strobe, then checks health for game over.
module combat_resolver
    import combat_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED    = 8'hA5,
    parameter int         SPECIAL_COST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] move_p1,
    input  logic [1:0] move_p2,
    input  logic [2:0] speed_p1,
    input  logic [2:0] speed_p2,
    input  logic [2:0] dodge_p1,
    input  logic [2:0] dodge_p2,
    input  logic [4:0] special_p1,
    input  logic [4:0] special_p2,
    input  logic [8:0] health_p1,
    input  logic [8:0] health_p2,
    output logic [5:0] dmg_to_p1,
    output logic [5:0] dmg_to_p2,
    output logic [2:0] cost_p1,
    output logic [2:0] cost_p2,
    output logic       en_p1,
    output logic       en_p2,
    output logic       upd_p1,
    output logic       upd_p2,
    output logic       busy,
    output logic       done,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam logic [4:0] SPC_METER = 5'(SPECIAL_COST);
    localparam logic [2:0] SPC_COST  = 3'(SPECIAL_COST);

    state_t     r_state, w_state_next;
    move_t      r_mv1, r_mv2;
    logic       r_p1_first, r_kill;
    logic [5:0] r_dmg1, r_dmg2;
    logic [2:0] r_cost1, r_cost2;
    logic       r_en1, r_en2, r_game_over;
    logic [1:0] r_winner;

    logic [7:0] w_lfsr;
    logic [3:0] w_unused_lfsr_hi;
    logic       w_first_phase, w_a_is_p1, w_hit, w_kill, w_p1_dead, w_p2_dead;
    move_t      w_mv_a, w_mv_d;
    attack_t    w_atk;
    logic [5:0] w_dmg;
    logic [4:0] w_dodge_sum;
    logic [3:0] w_eff_dodge;
    logic [8:0] w_health_d;

    lfsr8_roller u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .lfsr (w_lfsr)
    );
    assign w_unused_lfsr_hi = w_lfsr[7:4];

    // Attacker/defender roles flip between the first and second half of the turn.
    assign w_first_phase = (r_state == S_ATK1) || (r_state == S_STB1) || (r_state == S_WAIT1);
    assign w_a_is_p1     = w_first_phase ? r_p1_first : ~r_p1_first;
    assign w_mv_a        = w_a_is_p1 ? r_mv1 : r_mv2;
    assign w_mv_d        = w_a_is_p1 ? r_mv2 : r_mv1;
    assign w_atk         = attack_of(w_mv_a, w_a_is_p1 ? special_p1 : special_p2, SPC_METER, SPC_COST);
    assign w_dmg         = (w_mv_d == MV_GUARD) ? (w_atk.dmg >> 1) : w_atk.dmg;
    assign w_dodge_sum   = {2'b00, (w_a_is_p1 ? dodge_p2 : dodge_p1)}
                         + ((w_mv_a == MV_HEAVY) ? HEAVY_DODGE_BONUS : 5'd0);
    assign w_eff_dodge   = (w_dodge_sum > 5'd15) ? 4'd15 : w_dodge_sum[3:0];
    assign w_hit         = (w_lfsr[3:0] >= w_eff_dodge);
    assign w_health_d    = w_a_is_p1 ? health_p2 : health_p1;
    assign w_kill        = w_hit && ({3'b000, w_dmg} >= w_health_d);
    assign w_p1_dead     = (health_p1 == 9'd0);
    assign w_p2_dead     = (health_p2 == 9'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_LATCH;
            S_LATCH: w_state_next = S_ATK1;
            S_ATK1:  w_state_next = S_STB1;
            S_STB1:  w_state_next = S_WAIT1;
            S_WAIT1: w_state_next = r_kill ? S_CHECK : S_ATK2;
            S_ATK2:  w_state_next = S_STB2;
            S_STB2:  w_state_next = S_WAIT2;
            S_WAIT2: w_state_next = S_CHECK;
            S_CHECK: w_state_next = (w_p1_dead || w_p2_dead) ? S_OVER : S_IDLE;
            S_OVER:  w_state_next = S_OVER;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        upd_p1 = 1'b0;
        upd_p2 = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE, S_OVER: ;
            S_STB1, S_STB2: begin
                upd_p1 = ~w_a_is_p1;
                upd_p2 = w_a_is_p1;
                busy   = 1'b1;
            end
            S_CHECK: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: busy = 1'b1;
        endcase
    end

    // Bus registers: loaded in ATK, held through STB/WAIT, cleared as the turn closes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mv1       <= MV_LIGHT;
            r_mv2       <= MV_LIGHT;
            r_p1_first  <= 1'b0;
            r_kill      <= 1'b0;
            r_dmg1      <= 6'd0;
            r_dmg2      <= 6'd0;
            r_cost1     <= 3'd0;
            r_cost2     <= 3'd0;
            r_en1       <= 1'b0;
            r_en2       <= 1'b0;
            r_game_over <= 1'b0;
            r_winner    <= WIN_NONE;
        end else begin
            case (r_state)
                S_LATCH: begin
                    r_mv1      <= move_t'(move_p1);
                    r_mv2      <= move_t'(move_p2);
                    r_p1_first <= (speed_p1 >= speed_p2);
                    r_kill     <= 1'b0;
                end
                S_ATK1, S_ATK2: begin
                    if (r_state == S_ATK1) r_kill <= w_kill;
                    r_dmg1  <= w_a_is_p1 ? 6'd0 : w_dmg;
                    r_dmg2  <= w_a_is_p1 ? w_dmg : 6'd0;
                    r_en1   <= ~w_a_is_p1 & w_hit;
                    r_en2   <= w_a_is_p1 & w_hit;
                    r_cost1 <= w_a_is_p1 ? w_atk.cost : 3'd0;
                    r_cost2 <= w_a_is_p1 ? 3'd0 : w_atk.cost;
                end
                S_CHECK: begin
                    r_dmg1  <= 6'd0;
                    r_dmg2  <= 6'd0;
                    r_en1   <= 1'b0;
                    r_en2   <= 1'b0;
                    r_cost1 <= 3'd0;
                    r_cost2 <= 3'd0;
                    if (w_p1_dead || w_p2_dead) begin
                        r_game_over <= 1'b1;
                        r_winner    <= (w_p1_dead && w_p2_dead) ? WIN_DRAW :
                                       (w_p2_dead ? WIN_P1 : WIN_P2);
                    end
                end
                default: ;
            endcase
        end
    end

    assign dmg_to_p1 = r_dmg1;
    assign dmg_to_p2 = r_dmg2;
    assign cost_p1   = r_cost1;
    assign cost_p2   = r_cost2;
    assign en_p1     = r_en1;
    assign en_p2     = r_en2;
    assign game_over = r_game_over;
    assign winner    = r_winner;

endmodule

// File: tb/tb_combat_resolver.sv
// Directed bench for combat_resolver: steps whole turns, records outputs per cycle after start,
// and checks strobe timing, damage/cost/enable values, dodge rolls, kills and game over.
module tb_combat_resolver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] move_p1 = 2'd0, move_p2 = 2'd0;
    logic [2:0] speed_p1 = 3'd0, speed_p2 = 3'd0;
    logic [2:0] dodge_p1 = 3'd0, dodge_p2 = 3'd0;
    logic [4:0] special_p1 = 5'd0, special_p2 = 5'd0;
    logic [8:0] health_p1 = 9'd150, health_p2 = 9'd175;
    logic [5:0] dmg_to_p1, dmg_to_p2;
    logic [2:0] cost_p1, cost_p2;
    logic       en_p1, en_p2, upd_p1, upd_p2, busy, done, game_over;
    logic [1:0] winner;

    int checks = 0;
    int errors = 0;

    // Per-cycle record of one turn; index k = k-th cycle after the edge that samples start.
    logic       u1 [1:10], u2 [1:10], e1 [1:10], e2 [1:10], dn [1:10], bz [1:10];
    logic [5:0] d1 [1:10], d2 [1:10];
    logic [2:0] c1 [1:10], c2 [1:10];
    logic [3:0] roll [1:10];
    logic [7:0] m_lfsr;

    combat_resolver dut (
        .clk(clk), .rst(rst), .start(start),
        .move_p1(move_p1), .move_p2(move_p2),
        .speed_p1(speed_p1), .speed_p2(speed_p2),
        .dodge_p1(dodge_p1), .dodge_p2(dodge_p2),
        .special_p1(special_p1), .special_p2(special_p2),
        .health_p1(health_p1), .health_p2(health_p2),
        .dmg_to_p1(dmg_to_p1), .dmg_to_p2(dmg_to_p2),
        .cost_p1(cost_p1), .cost_p2(cost_p2),
        .en_p1(en_p1), .en_p2(en_p2),
        .upd_p1(upd_p1), .upd_p2(upd_p2),
        .busy(busy), .done(done),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    // Reference dice: x^8+x^6+x^5+x^4+1 Fibonacci register from seed A5.
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 8'hA5;
        else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse start at a negedge, then record ten cycles; the stat-block model applies hits on strobe.
    task automatic run_turn;
        start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            u1[i] = upd_p1; u2[i] = upd_p2; e1[i] = en_p1; e2[i] = en_p2;
            d1[i] = dmg_to_p1; d2[i] = dmg_to_p2; c1[i] = cost_p1; c2[i] = cost_p2;
            dn[i] = done; bz[i] = busy; roll[i] = m_lfsr[3:0];
            if (upd_p1 && en_p1) health_p1 = ({3'b0, dmg_to_p1} >= health_p1) ? 9'd0 : health_p1 - {3'b0, dmg_to_p1};
            if (upd_p2 && en_p2) health_p2 = ({3'b0, dmg_to_p2} >= health_p2) ? 9'd0 : health_p2 - {3'b0, dmg_to_p2};
        end
        $display("turn mv=%0d/%0d spd=%0d/%0d upd2@3=%0d upd1@6=%0d dmg2=%0d dmg1=%0d done@8=%0d hp=%0d/%0d",
                 move_p1, move_p2, speed_p1, speed_p2, u2[3], u1[6], d2[3], d1[6], dn[8], health_p1, health_p2);
    endtask

    initial begin
        int n_u1, n_u2, n_bz, n_dn;
        logic [3:0] eff;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_game_over", game_over, 0);
        chk("reset_lfsr", dut.w_lfsr, 8'hA5);
        rst = 1'b0;

        // Reset asserted while STB1 is strobing.
        speed_p1 = 3'd6; speed_p2 = 3'd4;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("pre_rst_upd_p2", upd_p2, 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_upd_p2", upd_p2, 0);
        chk("rst_dmg_to_p2", dmg_to_p2, 0);
        chk("rst_en_p2", en_p2, 0);
        chk("rst_busy", busy, 0);
        chk("rst_lfsr", dut.w_lfsr, 8'hA5);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        $display("reset mid-STB1 applied");

        // Normal turn: p1 faster, both light.
        run_turn();
        chk("n_upd_p2_c3", u2[3], 1);
        chk("n_dmg_p2_c3", d2[3], 8);
        chk("n_en_p2_c3", e2[3], 1);
        chk("n_en_p1_c3", e1[3], 0);
        chk("n_upd_p1_c3", u1[3], 0);
        chk("n_upd_p1_c6", u1[6], 1);
        chk("n_dmg_p1_c6", d1[6], 8);
        chk("n_en_p1_c6", e1[6], 1);
        chk("n_upd_p2_c6", u2[6], 0);
        chk("n_done_c7", dn[7], 0);
        chk("n_done_c8", dn[8], 1);
        chk("n_busy_c1", bz[1], 1);
        chk("n_busy_c9", bz[9], 0);
        n_u1 = 0; n_u2 = 0;
        for (int i = 1; i <= 10; i++) begin n_u1 += int'(u1[i]); n_u2 += int'(u2[i]); end
        chk("n_strobe_count_p1", n_u1, 1);
        chk("n_strobe_count_p2", n_u2, 1);
        chk("n_game_over", game_over, 0);

        // Tie on speed: p1 first. Then p2 faster.
        speed_p1 = 3'd4; speed_p2 = 3'd4;
        run_turn();
        chk("tie_upd_p2_c3", u2[3], 1);
        chk("tie_upd_p1_c6", u1[6], 1);
        speed_p1 = 3'd3; speed_p2 = 3'd5;
        run_turn();
        chk("p2f_upd_p1_c3", u1[3], 1);
        chk("p2f_dmg_p1_c3", d1[3], 8);
        chk("p2f_upd_p2_c6", u2[6], 1);

        // Specials: unaffordable, affordable, into a guard.
        speed_p1 = 3'd6; speed_p2 = 3'd4;
        move_p1 = 2'd2; special_p1 = 5'd3;
        run_turn();
        chk("sp3_dmg_p2", d2[3], 8);
        chk("sp3_cost_p1", c1[3], 0);
        special_p1 = 5'd10;
        run_turn();
        chk("sp10_dmg_p2", d2[3], 30);
        chk("sp10_cost_p1", c1[3], 4);
        chk("sp10_cost_p2", c2[3], 0);
        move_p2 = 2'd3;
        run_turn();
        chk("grd_dmg_p2", d2[3], 15);
        chk("grd_cost_p1", c1[3], 4);
        chk("grd_dmg_p1", d1[6], 0);
        chk("grd_upd_p1_c6", u1[6], 1);
        chk("grd_cost_p2", c2[6], 0);

        // Dodge: p2 dodge 7, p1 alternates light/heavy (heavy adds 2).
        move_p2 = 2'd0; special_p1 = 5'd0; dodge_p2 = 3'd7;
        health_p1 = 9'd300; health_p2 = 9'd300;
        for (int t = 0; t < 6; t++) begin
            move_p1 = (t % 2 == 1) ? 2'd1 : 2'd0;
            run_turn();
            eff = (t % 2 == 1) ? 4'd9 : 4'd7;
            chk("dg_upd_p2", u2[3], 1);
            chk("dg_en_p2", e2[3], (roll[2] >= eff) ? 1 : 0);
            chk("dg_dmg_p2", d2[3], (t % 2 == 1) ? 16 : 8);
        end
        chk("dg_lfsr_track", dut.w_lfsr, m_lfsr);

        // Kill: p2 dies on the first strike; turn ends early.
        move_p1 = 2'd0; move_p2 = 2'd0; dodge_p2 = 3'd0;
        health_p1 = 9'd100; health_p2 = 9'd8;
        run_turn();
        chk("k_upd_p2_c3", u2[3], 1);
        chk("k_done_c5", dn[5], 1);
        n_u1 = 0; n_u2 = 0;
        for (int i = 1; i <= 10; i++) begin n_u1 += int'(u1[i]); n_u2 += int'(u2[i]); end
        chk("k_strobes_p1", n_u1, 0);
        chk("k_strobes_p2", n_u2, 1);
        chk("k_game_over", game_over, 1);
        chk("k_winner", winner, 1);

        // Start is ignored once the game is over.
        run_turn();
        n_bz = 0; n_dn = 0;
        for (int i = 1; i <= 10; i++) begin n_bz += int'(bz[i]); n_dn += int'(dn[i]); end
        chk("over_busy", n_bz, 0);
        chk("over_done", n_dn, 0);
        chk("over_game_over", game_over, 1);
        chk("over_winner", winner, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/combat_resolver.md
Name: combat_resolver

Overview:
Turn sequencer that sits directly upstream of the two per-player character stat blocks. Each turn it accepts both players' moves and orders attacks by speed. It rolls dodge with an LFSR, computes damage and special cost, then drives each stat block's damage/cost/en inputs and its update strobe. After the turn it reads back health to detect game over.

Parameters:
LFSR_SEED, 8'hA5, reset value of dodge LFSR; a value of 0 is replaced by 8'h01
SPECIAL_COST, 4, special-meter cost of a special move (fits 3 bits)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
start  input  1  one-cycle request to resolve a turn; ignored while busy or game_over
move_p1, move_p2  input  2  0 light, 1 heavy, 2 special, 3 guard
speed_p1, speed_p2  input  3  speed from each stat block
dodge_p1, dodge_p2  input  3  dodge from each stat block
special_p1, special_p2  input  5  current special meter
health_p1, health_p2  input  9  current health
dmg_to_p1, dmg_to_p2  output  6  damage bus into each stat block
cost_p1, cost_p2  output  3  special cost into each stat block
en_p1, en_p2  output  1  hit-enable into each stat block
upd_p1, upd_p2  output  1  one-cycle update strobe into each stat block
busy  output  1  high from LATCH through CHECK
done  output  1  one-cycle pulse at end of turn
game_over  output  1  sticky until rst
winner  output  2  0 none, 1 p1, 2 p2, 3 draw

Behaviour:
- Reset (async): all outputs 0, FSM to IDLE, LFSR to seed. Reset mid-turn aborts immediately: upd_* drop in the same instant and no further strobe is issued.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. It advances every clock regardless of state. roll = lfsr[3:0].
- FSM states: IDLE, LATCH, ATK1, STB1, WAIT1, ATK2, STB2, WAIT2, CHECK, OVER.
- IDLE -> LATCH on start. LATCH captures moves, speeds and order: first attacker is the higher speed; on a tie p1 goes first.
- ATK1 / ATK2 (attacker A, defender D):
  - Register damage onto dmg_to_D, set en_D, and drive cost_A.
  - All three are held stable until the next ATK or CHECK.
  - The non-target en is 0.
- Damage table:
  - light: 8
  - heavy: 16; defender effective dodge +2 (saturate at 15)
  - special: 30 with cost SPECIAL_COST if special_A >= SPECIAL_COST; otherwise treated as light with cost 0
  - guard: 0
  - Defender guarding halves incoming damage (floor, >>1).
- Dodge: hit = (roll >= effective dodge_D). A miss forces en_D=0; the strobe is still issued.
- STB1 / STB2: upd_D=1 for exactly one cycle. WAIT1 / WAIT2: upd low; the data bus is held.
- Kill: in ATK1, if the hit lands and damage >= health_D, set kill. WAIT1 then goes directly to CHECK, skipping the second attack.
- CHECK:
  - done=1 for one cycle.
  - If health_p1==0 or health_p2==0: game_over=1; winner = 1 (p2 dead), 2 (p1 dead), 3 (both dead); go to OVER.
  - Otherwise go to IDLE.
- OVER: holds all outputs; start is ignored; only rst exits.
- Latency:
  - With start sampled at edge 0: first strobe in cycle 3, second in cycle 6, done in cycle 8.
  - Kill path: done in cycle 5.
- All arithmetic is unsigned. Damage never exceeds 30, so it fits 6 bits.

Decomposition:
- combat_pkg holds:
  - move enum (MV_LIGHT, MV_HEAVY, MV_SPECIAL, MV_GUARD)
  - FSM state enum
  - constants DMG_LIGHT=8, DMG_HEAVY=16, DMG_SPECIAL=30, HEAVY_DODGE_BONUS=2
  - winner encoding
- One sub-module: lfsr8_roller (clk, rst, seed -> lfsr value). It is reused later for AI move selection.

Test Plan:
- Reset mid-STB1: assert rst → upd_p2 drops, all outputs 0, busy 0, LFSR=8'hA5; next start completes a normal turn.
- speed 6/4, dodge 0/0, both light, health 150/175 → upd_p2 cycle 3 with dmg_to_p2=8, en_p2=1; upd_p1 cycle 6 with dmg_to_p1=8; done cycle 8; game_over 0.
- Equal speed 4/4 → p1 attacks first: upd_p2 strobes before upd_p1.
- p1 special with special_p1=3 → dmg_to_p2=8, cost_p1=0. With special_p1=10 → dmg_to_p2=30, cost_p1=4. With p2 guarding and special_p1=10 → dmg_to_p2=15; p2 strikes back with dmg_to_p1=0, and upd_p1 still strobes.
- Kill: p1 faster, light, dodge_p2=0, health_p2=8; bench model drives health_p2 to 0 on strobe → single strobe, done cycle 5, game_over=1, winner=1. A later start is ignored.
- Dodge: dodge_p2=7, force several turns → en_p2=0 exactly when lfsr[3:0]<7 at ATK; upd_p2 strobes every turn.
